// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path: opcodes, default widths,
// fetch FSM state encoding and the opcode field position.
package isa_pkg;

  localparam int DEF_CONTENT_SIZE  = 16;
  localparam int DEF_INSTRUCT_SIZE = 32;
  localparam int DEF_CNT_SIZE      = 16;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_LOAD = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // True when the opcode field matches the configured halt opcode.
  function automatic logic is_halt_op(input logic [5:0] op, input logic [5:0] halt_op);
    return (op == halt_op);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the instruction ROM and decode.
// The slave modport is the fetch controller's view.
interface instr_fetch_ctrl_if #(
  parameter int CONTENT_SIZE  = isa_pkg::DEF_CONTENT_SIZE,
  parameter int INSTRUCT_SIZE = isa_pkg::DEF_INSTRUCT_SIZE,
  parameter int CNT_SIZE      = isa_pkg::DEF_CNT_SIZE
);

  logic                     i_start;
  logic [CONTENT_SIZE-1:0]  i_start_pc;
  logic                     i_redirect;
  logic [CONTENT_SIZE-1:0]  i_redirect_pc;
  logic [CONTENT_SIZE-1:0]  o_rom_addr;
  logic [INSTRUCT_SIZE-1:0] i_rom_instr;
  logic [INSTRUCT_SIZE-1:0] o_instr;
  logic [CONTENT_SIZE-1:0]  o_instr_pc;
  logic                     o_instr_valid;
  logic                     i_instr_ready;
  logic                     o_busy;
  logic                     o_halted;
  logic [CNT_SIZE-1:0]      o_fetch_count;

  modport slave (
    input  i_start, i_start_pc, i_redirect, i_redirect_pc,
    input  i_rom_instr, i_instr_ready,
    output o_rom_addr, o_instr, o_instr_pc, o_instr_valid,
    output o_busy, o_halted, o_fetch_count
  );

  modport master (
    output i_start, i_start_pc, i_redirect, i_redirect_pc,
    output i_rom_instr, i_instr_ready,
    input  o_rom_addr, o_instr, o_instr_pc, o_instr_valid,
    input  o_busy, o_halted, o_fetch_count
  );

endinterface

// File: rtl/fetch_out_reg.sv
// Valid/ready output stage toward decode. Holds one fetched word and the
// address it came from. Flush has priority over load and over acceptance.
module fetch_out_reg #(
  parameter int CONTENT_SIZE  = 16,
  parameter int INSTRUCT_SIZE = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic                     i_flush,
  input  logic                     i_ready,
  input  logic [INSTRUCT_SIZE-1:0] i_instr,
  input  logic [CONTENT_SIZE-1:0]  i_pc,
  output logic [INSTRUCT_SIZE-1:0] o_instr,
  output logic [CONTENT_SIZE-1:0]  o_pc,
  output logic                     o_valid
);

  logic [INSTRUCT_SIZE-1:0] r_instr;
  logic [CONTENT_SIZE-1:0]  r_pc;
  logic                     r_valid;

  // Output register: flush drops the word, load captures a new one,
  // an accept without a new load empties the stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= {INSTRUCT_SIZE{1'b0}};
      r_pc    <= {CONTENT_SIZE{1'b0}};
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational ROM, and feeds
// decode through a one-entry valid/ready stage. Handles start, redirect,
// stall and halt-on-opcode, and counts words accepted by decode.
module instr_fetch_ctrl
  import isa_pkg::*;
#(
  parameter int         CONTENT_SIZE  = DEF_CONTENT_SIZE,
  parameter int         INSTRUCT_SIZE = DEF_INSTRUCT_SIZE,
  parameter logic [5:0] HALT_OPCODE   = OP_HALT,
  parameter int         CNT_SIZE      = DEF_CNT_SIZE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  instr_fetch_ctrl_if.slave bus
);

  fetch_state_e              r_state;
  logic [CONTENT_SIZE-1:0]   r_pc;
  logic [CNT_SIZE-1:0]       r_fetch_count;
  logic                      r_busy;
  logic                      r_halted;

  logic [INSTRUCT_SIZE-1:0]  w_out_instr;
  logic [CONTENT_SIZE-1:0]   w_out_pc;
  logic                      w_out_valid;

  logic                      w_acc;
  logic                      w_flush;
  logic                      w_load;
  logic                      w_halt_word;
  logic                      w_count_en;
  logic [CONTENT_SIZE-1:0]   w_pc_inc;
  logic [CNT_SIZE-1:0]       w_count_inc;
  logic                      w_count_sat;

  // Handshake, flush and load decisions for this cycle.
  always_comb begin
    w_acc       = w_out_valid & bus.i_instr_ready;
    w_halt_word = is_halt_op(bus.i_rom_instr[OPCODE_MSB:OPCODE_LSB], HALT_OPCODE);
    w_flush     = 1'b0;
    if (r_state == IDLE) begin
      w_flush = 1'b0;
    end else if (bus.i_redirect) begin
      w_flush = 1'b1;
    end else if ((r_state == FETCH) && bus.i_start) begin
      // A start while fetching behaves as a redirect to the start address.
      w_flush = 1'b1;
    end else begin
      w_flush = 1'b0;
    end
    w_load      = (r_state == FETCH) & (~w_out_valid | bus.i_instr_ready) & ~w_flush;
    w_count_en  = w_acc & ~w_flush;
    w_pc_inc    = r_pc + {{(CONTENT_SIZE-1){1'b0}}, 1'b1};
    w_count_inc = r_fetch_count + {{(CNT_SIZE-1){1'b0}}, 1'b1};
    w_count_sat = (r_fetch_count == {CNT_SIZE{1'b1}});
  end

  // Fetch FSM with PC, status flags and the saturating accept counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_pc          <= {CONTENT_SIZE{1'b0}};
      r_fetch_count <= {CNT_SIZE{1'b0}};
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      if (w_count_en && !w_count_sat) begin
        r_fetch_count <= w_count_inc;
      end
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_state  <= FETCH;
            r_pc     <= bus.i_start_pc;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        FETCH: begin
          if (bus.i_start) begin
            r_pc <= bus.i_start_pc;
          end else if (bus.i_redirect) begin
            r_pc <= bus.i_redirect_pc;
          end else if (w_load) begin
            if (w_halt_word) begin
              // The halt word is captured but the PC stays on it.
              r_state  <= HALTED;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end
        HALTED: begin
          if (bus.i_start) begin
            r_state  <= FETCH;
            r_pc     <= bus.i_start_pc;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end else if (bus.i_redirect) begin
            r_state  <= FETCH;
            r_pc     <= bus.i_redirect_pc;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  fetch_out_reg #(
    .CONTENT_SIZE  (CONTENT_SIZE),
    .INSTRUCT_SIZE (INSTRUCT_SIZE)
  ) u_out_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_ready (bus.i_instr_ready),
    .i_instr (bus.i_rom_instr),
    .i_pc    (r_pc),
    .o_instr (w_out_instr),
    .o_pc    (w_out_pc),
    .o_valid (w_out_valid)
  );

  assign bus.o_rom_addr    = r_pc;
  assign bus.o_instr       = w_out_instr;
  assign bus.o_instr_pc    = w_out_pc;
  assign bus.o_instr_valid = w_out_valid;
  assign bus.o_busy        = r_busy;
  assign bus.o_halted      = r_halted;
  assign bus.o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: ROM model, scoreboard of expected
// (pc, instr) pairs, and one task per scenario.
module tb_instr_fetch_ctrl;
  import isa_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ROM contents: small program at 0..3, ADD words tagged with the address elsewhere.
  function automatic logic [31:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h0801_0000;
      16'h0001: return 32'h0822_0001;
      16'h0002: return 32'h0440_0800;
      16'h0003: return 32'hFC00_0000;
      default:  return {OP_ADD, 10'd0, a};
    endcase
  endfunction

  always_comb bus.i_rom_instr = rom_word(bus.o_rom_addr);

  // Scoreboard: every word decode really takes (not flushed) must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && bus.o_instr_valid && bus.i_instr_ready && !bus.i_redirect && !bus.i_start) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no word", bus.o_instr_pc, bus.o_instr);
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus.o_instr_pc, bus.o_instr} !== mon_e) begin
          failures++;
          $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h",
                   bus.o_instr_pc, bus.o_instr, mon_e.pc, mon_e.instr);
        end
      end
      exp_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] pc);
    sb_q.push_back({pc, rom_word(pc)});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus.o_instr_valid, bus.o_busy, bus.o_halted} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 000", {bus.o_instr_valid, bus.o_busy, bus.o_halted});
    end
    checks++;
    if ({bus.o_instr, bus.o_instr_pc, bus.o_rom_addr, bus.o_fetch_count} !== 80'h0) begin
      failures++;
      $display("FAIL reset_data: got %h, required 0", {bus.o_instr, bus.o_instr_pc, bus.o_rom_addr, bus.o_fetch_count});
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: got busy=%b, required 0", bus.o_busy);
    end
  endtask

  task automatic test_basic();
    bus.i_instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    bus.i_start = 1'b1;
    bus.i_start_pc = 16'h0000;
    step();
    bus.i_start = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_instr_valid} !== 2'b10) begin
      failures++;
      $display("FAIL basic_start: got busy,valid=%b, required 10", {bus.o_busy, bus.o_instr_valid});
    end
    step();
    checks++;
    if ({bus.o_instr_valid, bus.o_instr_pc} !== {1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL basic_first: got valid=%b pc=%h, required 1 0000", bus.o_instr_valid, bus.o_instr_pc);
    end
    step();
    step();
    step();
    checks++;
    if ({bus.o_instr_pc, bus.o_halted, bus.o_busy} !== {16'h0003, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL basic_halt: got pc=%h halted=%b busy=%b, required 0003 1 0",
               bus.o_instr_pc, bus.o_halted, bus.o_busy);
    end
    step();
    checks++;
    if ({bus.o_instr_valid, bus.o_fetch_count} !== {1'b0, 16'd4}) begin
      failures++;
      $display("FAIL basic_done: got valid=%b count=%0d, required 0 4", bus.o_instr_valid, bus.o_fetch_count);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_stall();
    bit done = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    bus.i_start = 1'b1;
    bus.i_start_pc = 16'h0000;
    step();
    bus.i_start = 1'b0;
    step();
    step();
    bus.i_instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.o_instr_valid, bus.o_instr_pc, bus.o_instr, bus.o_rom_addr} !==
          {1'b1, 16'h0001, rom_word(16'h0001), 16'h0002}) begin
        failures++;
        $display("FAIL stall_hold: got valid=%b pc=%h instr=%h addr=%h, required 1 0001 %h 0002",
                 bus.o_instr_valid, bus.o_instr_pc, bus.o_instr, bus.o_rom_addr, rom_word(16'h0001));
      end
    end
    bus.i_instr_ready = 1'b1;
    for (int i = 0; i < 12 && !done; i++) begin
      step();
      if (bus.o_halted && !bus.o_instr_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL stall_timeout: got no halt within 12 cycles, required halt");
    end
    checks++;
    if ({sb_q.size() == 0, bus.o_fetch_count} !== {1'b1, 16'd8}) begin
      failures++;
      $display("FAIL stall_drain: got pending=%0d count=%0d, required 0 8", sb_q.size(), bus.o_fetch_count);
    end
  endtask

  task automatic test_redirect();
    logic [15:0] saved;
    push_exp(16'h0000);
    push_exp(16'h0001);
    bus.i_start = 1'b1;
    bus.i_start_pc = 16'h0000;
    step();
    bus.i_start = 1'b0;
    step();
    step();
    step();
    bus.i_instr_ready = 1'b0;
    checks++;
    if ({bus.o_instr_valid, bus.o_instr_pc} !== {1'b1, 16'h0002}) begin
      failures++;
      $display("FAIL redir_pre: got valid=%b pc=%h, required 1 0002", bus.o_instr_valid, bus.o_instr_pc);
    end
    saved = 16'(exp_count);
    step();
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 16'h0010;
    bus.i_instr_ready = 1'b1;
    step();
    bus.i_redirect = 1'b0;
    push_exp(16'h0010);
    checks++;
    if ({bus.o_instr_valid, bus.o_fetch_count, bus.o_rom_addr} !== {1'b0, saved, 16'h0010}) begin
      failures++;
      $display("FAIL redir_flush: got valid=%b count=%0d addr=%h, required 0 %0d 0010",
               bus.o_instr_valid, bus.o_fetch_count, bus.o_rom_addr, saved);
    end
    step();
    checks++;
    if ({bus.o_instr_valid, bus.o_instr_pc} !== {1'b1, 16'h0010}) begin
      failures++;
      $display("FAIL redir_target: got valid=%b pc=%h, required 1 0010", bus.o_instr_valid, bus.o_instr_pc);
    end
    step();
    bus.i_instr_ready = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL redir_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_start_redirect();
    bus.i_start = 1'b1;
    bus.i_start_pc = 16'h0005;
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 16'h0009;
    step();
    bus.i_start = 1'b0;
    bus.i_redirect = 1'b0;
    push_exp(16'h0005);
    bus.i_instr_ready = 1'b1;
    checks++;
    if (bus.o_instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL both_flush: got valid=%b, required 0", bus.o_instr_valid);
    end
    step();
    checks++;
    if ({bus.o_instr_valid, bus.o_instr_pc} !== {1'b1, 16'h0005}) begin
      failures++;
      $display("FAIL both_pc: got valid=%b pc=%h, required 1 0005", bus.o_instr_valid, bus.o_instr_pc);
    end
    step();
    bus.i_instr_ready = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL both_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_wrap();
    bus.i_start = 1'b1;
    bus.i_start_pc = 16'hFFFE;
    step();
    bus.i_start = 1'b0;
    push_exp(16'hFFFE);
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    bus.i_instr_ready = 1'b1;
    step();
    checks++;
    if (bus.o_instr_pc !== 16'hFFFE) begin
      failures++;
      $display("FAIL wrap_0: got pc=%h, required FFFE", bus.o_instr_pc);
    end
    step();
    checks++;
    if ({bus.o_instr_pc, bus.o_rom_addr} !== {16'hFFFF, 16'h0000}) begin
      failures++;
      $display("FAIL wrap_1: got pc=%h addr=%h, required FFFF 0000", bus.o_instr_pc, bus.o_rom_addr);
    end
    step();
    checks++;
    if (bus.o_instr_pc !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_2: got pc=%h, required 0000", bus.o_instr_pc);
    end
    step();
    bus.i_instr_ready = 1'b0;
    checks++;
    if ({sb_q.size() == 0, bus.o_fetch_count} !== {1'b1, 16'(exp_count)}) begin
      failures++;
      $display("FAIL wrap_drain: got pending=%0d count=%0d, required 0 %0d",
               sb_q.size(), bus.o_fetch_count, exp_count);
    end
  endtask

  task automatic test_async_reset();
    checks++;
    if (bus.o_instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre: got valid=%b, required 1", bus.o_instr_valid);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_instr_valid, bus.o_busy, bus.o_halted, bus.o_instr, bus.o_instr_pc,
         bus.o_rom_addr, bus.o_fetch_count} !== 83'h0) begin
      failures++;
      $display("FAIL arst_now: got valid=%b busy=%b pc=%h instr=%h addr=%h count=%0d, required all 0",
               bus.o_instr_valid, bus.o_busy, bus.o_instr_pc, bus.o_instr, bus.o_rom_addr, bus.o_fetch_count);
    end
    exp_count = 0;
    sb_q.delete();
    bus.i_instr_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({bus.o_busy, bus.o_instr_valid} !== 2'b00) begin
      failures++;
      $display("FAIL arst_idle: got busy,valid=%b, required 00", {bus.o_busy, bus.o_instr_valid});
    end
    push_exp(16'h0020);
    bus.i_start = 1'b1;
    bus.i_start_pc = 16'h0020;
    step();
    bus.i_start = 1'b0;
    step();
    checks++;
    if ({bus.o_instr_valid, bus.o_instr_pc} !== {1'b1, 16'h0020}) begin
      failures++;
      $display("FAIL arst_restart: got valid=%b pc=%h, required 1 0020", bus.o_instr_valid, bus.o_instr_pc);
    end
    step();
    bus.i_instr_ready = 1'b0;
    checks++;
    if ({sb_q.size() == 0, bus.o_fetch_count} !== {1'b1, 16'd1}) begin
      failures++;
      $display("FAIL arst_count: got pending=%0d count=%0d, required 0 1", sb_q.size(), bus.o_fetch_count);
    end
  endtask

  initial begin
    bus.i_start       = 1'b0;
    bus.i_start_pc    = 16'h0000;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 16'h0000;
    bus.i_instr_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_start_redirect();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the combinational instruction ROM. Owns the program counter and drives the ROM address. Registers each fetched word into an output stage toward decode, using a valid/ready handshake. Supports start, redirect (branch/jump), stall and halt-on-opcode, and keeps a fetch counter for debug.

Parameters:
CONTENT_SIZE, 16, PC / ROM address width
INSTRUCT_SIZE, 32, instruction width
HALT_OPCODE, 6'b111111, opcode in instr[31:26] that stops fetching
CNT_SIZE, 16, fetch counter width

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  pulse: load PC from i_start_pc and begin fetching
i_start_pc  input  CONTENT_SIZE  start address
i_redirect  input  1  pulse: flush and continue at i_redirect_pc
i_redirect_pc  input  CONTENT_SIZE  redirect target
o_rom_addr  output  CONTENT_SIZE  address to ROM (equals PC)
i_rom_instr  input  INSTRUCT_SIZE  ROM data, combinational from o_rom_addr
o_instr  output  INSTRUCT_SIZE  registered instruction to decode
o_instr_pc  output  CONTENT_SIZE  address o_instr was fetched from
o_instr_valid  output  1  o_instr/o_instr_pc valid
i_instr_ready  input  1  decode accepts this cycle
o_busy  output  1  state == FETCH
o_halted  output  1  state == HALTED
o_fetch_count  output  CNT_SIZE  instructions accepted by decode, saturating

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; PC=0; o_instr=0; o_instr_pc=0; o_instr_valid=0; o_fetch_count=0. Deassertion is sampled synchronously.
- o_rom_addr = PC (combinational). The ROM read resolves in the same cycle.
- Accept condition: acc = o_instr_valid & i_instr_ready.
- Load condition: load = (state==FETCH) & (!o_instr_valid | i_instr_ready) & !i_redirect.
- On load: o_instr<=i_rom_instr; o_instr_pc<=PC; o_instr_valid<=1; PC<=PC+1.
- PC arithmetic: modulo 2^CONTENT_SIZE, so 16'hFFFF wraps to 0 with no flag.
- Fetch latency: 1 cycle from PC to o_instr_valid. Throughput is 1 instruction/cycle while i_instr_ready=1.
- Stall: valid=1 and ready=0 → o_instr, o_instr_pc and PC hold. No ROM word is lost or repeated.
- acc without load → o_instr_valid<=0.
- State machine:
  - IDLE: i_start → FETCH; PC<=i_start_pc.
  - FETCH: a load whose i_rom_instr[31:26]==HALT_OPCODE still captures that word, but PC is not incremented and next state is HALTED.
  - HALTED: no loads; the pending halt word is still presented until accepted, then valid drops. i_start → FETCH with PC<=i_start_pc.
- i_start in FETCH: treated as a redirect to i_start_pc.
- Redirect (any state except IDLE; ignored in IDLE):
  - Highest priority: o_instr_valid<=0, discarding an unaccepted word even if ready=1 that cycle; that word is not counted.
  - PC<=i_redirect_pc.
  - From HALTED, state → FETCH.
  - Fetching resumes the next cycle.
- Simultaneous i_start and i_redirect: i_start wins, PC<=i_start_pc.
- o_fetch_count: increments on acc unless the same cycle has i_redirect (flushed). Saturates at all-ones. Cleared only by reset.
- Async reset mid-operation: immediate return to reset values; in-flight instruction dropped.

Decomposition:
- Shared package isa_pkg:
  - opcode constants OP_ADD=6'b000001, OP_LOAD=6'b000010, OP_HALT=6'b111111
  - CONTENT_SIZE/INSTRUCT_SIZE defaults
  - fetch state encoding IDLE=2'd0, FETCH=2'd1, HALTED=2'd2
  - opcode field slice positions [31:26]
- One natural sub-module: fetch_out_reg, the valid/ready output register holding instr+pc, with load/flush inputs.
- PC and FSM stay in the top module.

Test Plan:
- Reset, i_start with i_start_pc=0, ready=1, ROM={LOAD 0x08010000, LOAD 0x08220001, ADD 0x04400800, HALT 0xFC000000} → valid from cycle 1; pcs 0,1,2,3 on consecutive cycles; o_halted=1 after halt word; o_fetch_count=4.
- Same program, ready low for 3 cycles while o_instr_pc=1 → o_instr/o_instr_pc held at pc 1; after ready rises, sequence 1,2,3 with no duplicate or skip.
- Redirect to 0x0010 while valid=1, ready=0 at pc 2 → word 2 discarded and count unchanged; next valid word has o_instr_pc=0x0010.
- i_start and i_redirect in the same cycle (start_pc=5, redirect_pc=9) → next o_instr_pc=5.
- i_start_pc=16'hFFFE, non-halt words → o_instr_pc sequence FFFE, FFFF, 0000.
- Assert i_rst_n=0 mid-stream with valid=1 → all outputs 0 immediately (asynchronous); IDLE until the next i_start.
